seq_multiplier: RTL

Iterative shift-add multiplier: the parametrised, clocked successor to the combinational 64×64 multiplier. It accepts two WIDTH-bit operands over a valid/ready handshake and computes one partial product per cycle. It returns the full 2·WIDTH-bit product over a second valid/ready handshake, along with a flag saying whether the result fits in WIDTH bits. Signed or unsigned interpretation is selected per operation. It sits in the execute stage as the multi-cycle MUL unit.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/seq_multiplier_twos_neg.sv | 11 +
 rtl/seq_multiplier.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Ceiling log2, used to size the iteration counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_multiplier_twos_neg.sv
// Combinational two's-complement negation: o_neg = ~i_x + 1.
module twos_neg #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_x,
   output logic [W-1:0] o_neg
);

   assign o_neg = ~i_x + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle MUL unit: one shift-add iteration per cycle over magnitudes,
// sign applied once at the end, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one partial-product add/shift per cycle, WIDTH cycles
// FIX   | apply sign to accumulator, compute overflow
// DONE  | out_valid high, result held until out_ready
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               overflow,
   output logic               busy
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;
   logic                 r_signed;
   logic [2*WIDTH-1:0]   r_product;
   logic                 r_overflow;

   logic [WIDTH-1:0]     w_neg_a;
   logic [WIDTH-1:0]     w_neg_b;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_acc_step;
   logic [2*WIDTH-1:0]   w_neg_acc;
   logic [2*WIDTH-1:0]   w_corr;
   logic [WIDTH:0]       w_top;
   logic                 w_ovf;

   twos_neg #(.W(WIDTH))   u_neg_a   (.i_x(a),     .o_neg(w_neg_a));
   twos_neg #(.W(WIDTH))   u_neg_b   (.i_x(b),     .o_neg(w_neg_b));
   twos_neg #(.W(2*WIDTH)) u_neg_acc (.i_x(r_acc), .o_neg(w_neg_acc));

   // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
   assign w_mag_a = (is_signed && a[WIDTH-1]) ? w_neg_a : a;
   assign w_mag_b = (is_signed && b[WIDTH-1]) ? w_neg_b : b;

   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
   assign w_acc_step = {w_sum, r_acc[WIDTH-1:1]};

   assign w_corr = r_neg ? w_neg_acc : r_acc;
   assign w_top  = w_corr[2*WIDTH-1:WIDTH-1];
   assign w_ovf  = r_signed ? ~((&w_top) | ~(|w_top))
                            : (|w_corr[2*WIDTH-1:WIDTH]);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN:  if (r_cnt == CNT_LAST) w_state_nxt = FIX;
         FIX:  w_state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand    <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_signed   <= 1'b0;
         r_product  <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand  <= w_mag_a;
                  r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                  r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_signed <= is_signed;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= r_cnt + CNT_ONE;
            end
            FIX: begin
               r_product  <= w_corr;
               r_overflow <= w_ovf;
            end
            default: ;
         endcase
      end
   end

   assign product  = r_product;
   assign overflow = r_overflow;

endmodule
